// File: rtl/ul8_mem_pkg.sv
// ---------------------------------------------------------------------------
// Module : ul8_mem_pkg
// Brief  : Shared types and constants for the UL8 data-store RAM.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ul8_mem_pkg;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_RUN   = 1'b1
  } mem_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

`default_nettype wire

// File: rtl/ram_clr_ctrl.sv
// ---------------------------------------------------------------------------
// Module : ram_clr_ctrl
// Brief  : Clear sequencer: walks every address once, writing zero, after
//          reset or a clear request.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_clr_ctrl
  import ul8_mem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] c_LAST = '1;

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MEM_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_busy_nxt    = r_busy;
    case (r_state)
      MEM_CLEAR: begin
        // Requests arriving mid-clear are deliberately dropped, not queued.
        if (r_clr_ptr == c_LAST) begin
          w_state_nxt   = MEM_RUN;
          w_clr_ptr_nxt = '0;
          w_busy_nxt    = 1'b0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      MEM_RUN: begin
        if (clr_req) begin
          w_state_nxt   = MEM_CLEAR;
          w_clr_ptr_nxt = '0;
          w_busy_nxt    = 1'b1;
        end
      end
    endcase
  end

  assign busy     = r_busy;
  assign clr_we   = (r_state == MEM_CLEAR) && !rst;
  assign clr_addr = r_clr_ptr;

endmodule

`default_nettype wire

// File: rtl/ram_dp_clr.sv
// ---------------------------------------------------------------------------
// Module : ram_dp_clr
// Brief  : Dual-port synchronous RAM (A read/write, B read-only) with a
//          self-clearing sequencer for the UL8 CPU data store.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_dp_clr
  import ul8_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RDW_B  = RDW_OLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_a_wr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_b_data;

  ram_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // Single array write port; busy guarantees clear and port A never collide.
  assign w_a_wr  = a_en && a_we && !w_busy && !rst;
  assign w_we    = w_clr_we || w_a_wr;
  assign w_waddr = w_busy ? w_clr_addr : a_addr;
  assign w_wdata = w_busy ? '0 : a_wdata;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  generate
    if (RDW_B == RDW_NEW) begin : g_rdw_new
      assign w_b_data = (w_a_wr && (a_addr == b_addr)) ? a_wdata : r_mem[b_addr];
    end else begin : g_rdw_old
      assign w_b_data = r_mem[b_addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || w_busy) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (a_en) begin
        r_a_rdata <= a_we ? a_wdata : r_mem[a_addr];
      end
      if (b_en) begin
        r_b_rdata <= w_b_data;
      end
    end
  end

  assign busy    = w_busy;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
// ---------------------------------------------------------------------------
// Module : tb_ram_dp_clr
// Brief  : Self-checking bench for ram_dp_clr (three parameter sets).
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_dp_clr;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        a_en;
  logic        a_we;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata;
  logic        b_en;
  logic [7:0]  b_addr;

  logic        busy0, busy1, busy2;
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] a2, b2;

  int n_tests;
  int n_fail;

  // u0: 32x8 old-data RDW, u1: 32x8 new-data RDW, u2: 256x16 new-data RDW
  ram_dp_clr #(.DATA_W(8), .ADDR_W(5), .RDW_B(0)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr[4:0]), .a_wdata(a_wdata[7:0]), .a_rdata(a0),
    .b_en(b_en), .b_addr(b_addr[4:0]), .b_rdata(b0)
  );

  ram_dp_clr #(.DATA_W(8), .ADDR_W(5), .RDW_B(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr[4:0]), .a_wdata(a_wdata[7:0]), .a_rdata(a1),
    .b_en(b_en), .b_addr(b_addr[4:0]), .b_rdata(b1)
  );

  ram_dp_clr #(.DATA_W(16), .ADDR_W(8), .RDW_B(1)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a2),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, a word array plus the number of clear cycles left.
  logic [15:0] m   [3][256];
  int          cnt [3];
  logic [15:0] ea  [3];
  logic [15:0] eb  [3];

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int          d;
      int          aa;
      int          ba;
      logic [15:0] dmask;
      logic [15:0] wd;
      logic [15:0] oldb;
      d     = (k == 2) ? 256 : 32;
      dmask = (k == 2) ? 16'hFFFF : 16'h00FF;
      aa    = int'(a_addr) % d;
      ba    = int'(b_addr) % d;
      wd    = a_wdata & dmask;
      if (rst) begin
        cnt[k] = d;
        ea[k]  = '0;
        eb[k]  = '0;
      end else if (cnt[k] > 0) begin
        m[k][d - cnt[k]] = '0;
        cnt[k] = cnt[k] - 1;
        ea[k]  = '0;
        eb[k]  = '0;
      end else begin
        oldb = m[k][ba];
        if (a_en) begin
          if (a_we) begin
            m[k][aa] = wd;
            ea[k]    = wd;
          end else begin
            ea[k] = m[k][aa];
          end
        end
        if (b_en) begin
          eb[k] = (k != 0 && a_en && a_we && aa == ba) ? wd : oldb;
        end
        if (clr_req) cnt[k] = d;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("busy0", {31'd0, busy0}, {31'd0, cnt[0] > 0});
    chk("busy1", {31'd0, busy1}, {31'd0, cnt[1] > 0});
    chk("busy2", {31'd0, busy2}, {31'd0, cnt[2] > 0});
    chk("a_rdata0", {24'd0, a0}, {16'd0, ea[0]});
    chk("b_rdata0", {24'd0, b0}, {16'd0, eb[0]});
    chk("a_rdata1", {24'd0, a1}, {16'd0, ea[1]});
    chk("b_rdata1", {24'd0, b1}, {16'd0, eb[1]});
    chk("a_rdata2", {16'd0, a2}, {16'd0, ea[2]});
    chk("b_rdata2", {16'd0, b2}, {16'd0, eb[2]});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Counts edges until each size's busy drops; pulses clr_req mid-clear at req_at.
  task automatic measure(input int n_start, input int req_at, output int n0, output int n2);
    int  n;
    bit  d0;
    bit  d2;
    n  = n_start;
    d0 = 1'b0;
    d2 = 1'b0;
    n0 = -1;
    n2 = -1;
    while (!(d0 && d2) && n < 600) begin
      if (n == req_at)     clr_req = 1'b1;
      if (n == req_at + 3) clr_req = 1'b0;
      cyc();
      n++;
      if (!d0 && busy0 === 1'b0) begin n0 = n; d0 = 1'b1; end
      if (!d2 && busy2 === 1'b0) begin n2 = n; d2 = 1'b1; end
    end
    clr_req = 1'b0;
  endtask

  typedef struct {
    logic        a_en;
    logic        a_we;
    logic [7:0]  a_addr;
    logic [15:0] wd;
    logic        b_en;
    logic [7:0]  b_addr;
    logic [7:0]  ea;
    logic [7:0]  eb0;
    logic [7:0]  eb1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n2;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; clr_req = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_addr = '0;
    for (int k = 0; k < 3; k++) cnt[k] = 0;

    tbl[0] = '{1'b1, 1'b1, 8'd3, 16'h00A5, 1'b0, 8'd0, 8'hA5, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b1, 8'd3, 8'hA5, 8'hA5, 8'hA5};
    tbl[2] = '{1'b1, 1'b1, 8'd7, 16'h00A5, 1'b0, 8'd0, 8'hA5, 8'hA5, 8'hA5};
    tbl[3] = '{1'b1, 1'b1, 8'd7, 16'h005A, 1'b1, 8'd7, 8'h5A, 8'hA5, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 8'd9, 16'h0033, 1'b1, 8'd7, 8'h5A, 8'h5A, 8'h5A};
    tbl[5] = '{1'b1, 1'b0, 8'd0, 16'h0000, 1'b0, 8'd3, 8'h00, 8'h5A, 8'h5A};
    tbl[6] = '{1'b1, 1'b0, 8'd7, 16'h0000, 1'b1, 8'd3, 8'h5A, 8'hA5, 8'hA5};

    // Reset held three cycles, then one full clear
    repeat (3) cyc();
    rst = 1'b0;
    measure(0, -10, n0, n2);
    chk("t1_busy_len_32", n0, 32);
    chk("t1_busy_len_256", n2, 256);
    for (int i = 0; i < 256; i++) begin
      a_en = 1'b1; a_we = 1'b0; a_addr = 8'(i);
      b_en = 1'b1; b_addr = 8'(255 - i);
      cyc();
      chk("t1_clear_a0", {24'd0, a0}, 32'd0);
      chk("t1_clear_b2", {16'd0, b2}, 32'd0);
    end
    a_addr = 8'd0; b_addr = 8'd0;
    cyc();

    // Directed port A / port B / read-during-write table
    for (int i = 0; i < 7; i++) begin
      a_en = tbl[i].a_en; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].wd;
      b_en = tbl[i].b_en; b_addr = tbl[i].b_addr;
      cyc();
      chk($sformatf("tbl%0d_a0", i), {24'd0, a0}, {24'd0, tbl[i].ea});
      chk($sformatf("tbl%0d_b0", i), {24'd0, b0}, {24'd0, tbl[i].eb0});
      chk($sformatf("tbl%0d_b1", i), {24'd0, b1}, {24'd0, tbl[i].eb1});
    end

    // Wide pattern on the 256x16 instance
    a_en = 1'b1; a_we = 1'b1; a_addr = 8'h80; a_wdata = 16'hBEEF; b_en = 1'b0;
    cyc();
    chk("beef_wr_a2", {16'd0, a2}, 32'h0000BEEF);
    a_we = 1'b0; b_en = 1'b1; b_addr = 8'h80;
    cyc();
    chk("beef_rd_a2", {16'd0, a2}, 32'h0000BEEF);
    chk("beef_rd_b2", {16'd0, b2}, 32'h0000BEEF);

    // Clear request after writes; a write during busy must be dropped
    a_we = 1'b1; a_addr = 8'd0;  a_wdata = 16'h0011; b_en = 1'b0; cyc();
    a_addr = 8'd31; a_wdata = 16'h00FF; cyc();
    a_en = 1'b0; a_we = 1'b0; clr_req = 1'b1; cyc();
    clr_req = 1'b0; a_en = 1'b1; a_we = 1'b1; a_addr = 8'd4; a_wdata = 16'h0077; cyc();
    a_en = 1'b0; a_we = 1'b0;
    measure(1, -10, n0, n2);
    chk("t4_busy_len_32", n0, 32);
    chk("t4_busy_len_256", n2, 256);
    a_en = 1'b1;
    a_addr = 8'd0;  cyc(); chk("t4_rd0", {24'd0, a0}, 32'd0);  chk("t4_rd0_w", {16'd0, a2}, 32'd0);
    a_addr = 8'd4;  cyc(); chk("t4_rd4", {24'd0, a0}, 32'd0);  chk("t4_rd4_w", {16'd0, a2}, 32'd0);
    a_addr = 8'd31; cyc(); chk("t4_rd31", {24'd0, a0}, 32'd0); chk("t4_rd31_w", {16'd0, a2}, 32'd0);
    a_en = 1'b0;

    // Reset mid-clear restarts; clr_req during the clear does not extend it
    clr_req = 1'b1; cyc();
    clr_req = 1'b0;
    repeat (10) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    measure(0, 3, n0, n2);
    chk("t5_busy_len_32", n0, 32);
    chk("t5_busy_len_256", n2, 256);

    // Disabled ports with moving addresses must hold their outputs
    a_en = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = 16'h1234; b_en = 1'b1; b_addr = 8'd5; cyc();
    a_en = 1'b0; b_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_addr = 8'($urandom); b_addr = 8'($urandom); a_we = 1'($urandom); cyc();
      chk("t6_hold_a0", {24'd0, a0}, 32'h34);
      chk("t6_hold_b2", {16'd0, b2}, 32'h1234);
    end

    // Randomised traffic, with occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clr_req = ($urandom_range(0, 99) == 0);
      a_en    = 1'($urandom);
      a_we    = 1'($urandom);
      a_addr  = 8'($urandom_range(0, 40));
      a_wdata = 16'($urandom);
      b_en    = 1'($urandom);
      b_addr  = $urandom_range(0, 2) == 0 ? a_addr : 8'($urandom_range(0, 40));
      cyc();
    end
    rst = 1'b0; clr_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
